// File: rtl/rr_arbiter8_pkg.sv
// Shared types, sizes and helpers for the 8-way round-robin arbiter.
// Holds the FSM state encoding and the rotate function used by the priority search.
package rr_arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDXW  = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Rotate right so that result bit 0 is vec[amt]; the search origin lands on bit 0.
   function automatic logic [N_REQ-1:0] rot8(input logic [N_REQ-1:0] vec,
                                             input logic [IDXW-1:0]  amt);
      logic [2*N_REQ-1:0] dbl;
      dbl = {vec, vec};
      return dbl[amt +: N_REQ];
   endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The arbiter takes the slave view; requesters (or a bench) take the master view.
interface rr_arbiter8_if;
   import rr_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [IDXW-1:0]  gnt_idx;
   logic             gnt_valid;

   modport master (
      output req,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_idx,
      output gnt_valid
   );

endinterface

// File: rtl/rr_arbiter8_chk.sv
// Structural invariants of the arbiter outputs, kept apart from the datapath.
// Checks one-hot grant, valid/grant agreement, index/grant agreement and hold bound.
module rr_arbiter8_chk
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNTW     = 8
) (
   input logic             clk,
   input logic             rst_n,
   input logic [N_REQ-1:0] gnt,
   input logic [IDXW-1:0]  gnt_idx,
   input logic             gnt_valid,
   input logic [CNTW-1:0]  hold_cnt
);

   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(gnt));

   a_valid_match: assert property (@(posedge clk) disable iff (!rst_n)
      gnt_valid == (gnt != 8'h00));

   a_idx_match: assert property (@(posedge clk) disable iff (!rst_n)
      gnt_valid |-> (gnt == (8'h01 << gnt_idx)));

   a_hold_bound: assert property (@(posedge clk) disable iff (!rst_n)
      hold_cnt <= CNTW'(MAX_HOLD));

endmodule

// File: rtl/rr_arbiter8_prio_enc.sv
// Fixed-priority 8-to-3 encoder: reports the lowest set bit and whether any bit is set.
// Bit 0 wins, so callers rotate their vector to put the search origin there.
module prio_enc8_3
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] in,
   output logic [IDXW-1:0]  idx,
   output logic             any
);

   assign any = |in;

   // Lowest-set-bit select.
   always_comb begin
      idx = 3'd0;
      casez (in)
         8'b???????1: idx = 3'd0;
         8'b??????10: idx = 3'd1;
         8'b?????100: idx = 3'd2;
         8'b????1000: idx = 3'd3;
         8'b???10000: idx = 3'd4;
         8'b??100000: idx = 3'd5;
         8'b?1000000: idx = 3'd6;
         8'b10000000: idx = 3'd7;
         default:     idx = 3'd0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per grant.
// Grant, index and valid are registered; the search rotates from one past the last owner.
module rr_arbiter8
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int CNTW     = 8
) (
   input logic          clk,
   input logic          rst_n,
   rr_arbiter8_if.slave bus
);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [N_REQ-1:0] gnt_r;
   logic [N_REQ-1:0] gnt_nxt_s;
   logic [IDXW-1:0]  idx_r;
   logic [IDXW-1:0]  idx_nxt_s;
   logic             valid_r;
   logic             valid_nxt_s;
   logic [CNTW-1:0]  hold_r;
   logic [CNTW-1:0]  hold_nxt_s;
   logic [IDXW-1:0]  ptr_r;
   logic [IDXW-1:0]  ptr_nxt_s;

   logic [N_REQ-1:0] masked_s;
   logic [N_REQ-1:0] rot_s;
   logic [IDXW-1:0]  start_s;
   logic [IDXW-1:0]  enc_idx_s;
   logic [IDXW-1:0]  win_s;
   logic [CNTW-1:0]  max_hold_s;
   logic             enc_any_s;
   logic             owner_req_s;
   logic             hold_max_s;
   logic             take_new_s;
   logic             keep_s;

   assign max_hold_s  = CNTW'(MAX_HOLD);
   assign owner_req_s = |(bus.req & gnt_r);
   assign hold_max_s  = (hold_r == max_hold_s);

   // The current owner is masked out, so "any" means someone else is waiting.
   assign masked_s = bus.req & ~gnt_r;
   assign start_s  = ptr_r + 3'd1;
   assign rot_s    = rot8(masked_s, start_s);

   prio_enc8_3 u_enc (
      .in  (rot_s),
      .idx (enc_idx_s),
      .any (enc_any_s)
   );

   // Un-rotate: offset from the search origin, wrapping naturally in 3 bits.
   assign win_s = start_s + enc_idx_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decision.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (enc_any_s) begin
               state_nxt_s = GRANT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT: begin
            if (owner_req_s || enc_any_s) begin
               state_nxt_s = GRANT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output/datapath next values: new grant, keep current grant, or go idle.
   always_comb begin
      take_new_s  = 1'b0;
      keep_s      = 1'b0;
      gnt_nxt_s   = 8'h00;
      idx_nxt_s   = 3'd0;
      valid_nxt_s = 1'b0;
      hold_nxt_s  = {CNTW{1'b0}};
      ptr_nxt_s   = ptr_r;

      case (state_r)
         IDLE: begin
            take_new_s = enc_any_s;
            keep_s     = 1'b0;
         end
         GRANT: begin
            if (owner_req_s) begin
               take_new_s = hold_max_s & enc_any_s;
               keep_s     = ~(hold_max_s & enc_any_s);
            end else begin
               take_new_s = enc_any_s;
               keep_s     = 1'b0;
            end
         end
         default: begin
            take_new_s = 1'b0;
            keep_s     = 1'b0;
         end
      endcase

      if (take_new_s) begin
         gnt_nxt_s   = 8'h01 << win_s;
         idx_nxt_s   = win_s;
         valid_nxt_s = 1'b1;
         hold_nxt_s  = {{(CNTW-1){1'b0}}, 1'b1};
         ptr_nxt_s   = win_s;
      end else if (keep_s) begin
         gnt_nxt_s   = gnt_r;
         idx_nxt_s   = idx_r;
         valid_nxt_s = valid_r;
         // Saturate at the limit while nobody else is waiting.
         if (hold_max_s) begin
            hold_nxt_s = hold_r;
         end else begin
            hold_nxt_s = hold_r + {{(CNTW-1){1'b0}}, 1'b1};
         end
         ptr_nxt_s   = ptr_r;
      end else begin
         gnt_nxt_s   = 8'h00;
         idx_nxt_s   = 3'd0;
         valid_nxt_s = 1'b0;
         hold_nxt_s  = {CNTW{1'b0}};
         ptr_nxt_s   = ptr_r;
      end
   end

   // Registered grant outputs, hold counter and last-granted pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_r   <= 8'h00;
         idx_r   <= 3'd0;
         valid_r <= 1'b0;
         hold_r  <= {CNTW{1'b0}};
         ptr_r   <= 3'd7;
      end else begin
         gnt_r   <= gnt_nxt_s;
         idx_r   <= idx_nxt_s;
         valid_r <= valid_nxt_s;
         hold_r  <= hold_nxt_s;
         ptr_r   <= ptr_nxt_s;
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.gnt_idx   = idx_r;
   assign bus.gnt_valid = valid_r;

   rr_arbiter8_chk #(
      .MAX_HOLD (MAX_HOLD),
      .CNTW     (CNTW)
   ) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .gnt       (gnt_r),
      .gnt_idx   (idx_r),
      .gnt_valid (valid_r),
      .hold_cnt  (hold_r)
   );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: directed scenarios plus randomized request traffic,
// checked against an integer-level round-robin model.
module tb_rr_arbiter8;
   import rr_arb_pkg::*;

   localparam int MAX_HOLD = 16;

   logic clk = 1'b0;
   logic rst_n;

   rr_arbiter8_if bus ();

   rr_arbiter8 #(
      .MAX_HOLD (MAX_HOLD),
      .CNTW     (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] g;
      logic [2:0] i;
      logic       v;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: owner (-1 when idle), cycles held, last granted.
   int m_owner = -1;
   int m_held  = 0;
   int m_last  = 7;

   function automatic int scan(input logic [7:0] r, input int from);
      for (int k = 0; k < 8; k++) begin
         int c;
         c = (from + k) % 8;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Advance the model by one clock with request vector r and queue the expected outputs.
   task automatic model_step(input logic [7:0] r);
      exp_t       e;
      logic [7:0] others;
      if (m_owner < 0) begin
         if (r != 8'h00) begin
            m_owner = scan(r, (m_last + 1) % 8);
            m_held  = 1;
         end
      end else if (r[m_owner]) begin
         others = r;
         others[m_owner] = 1'b0;
         if (m_held < MAX_HOLD) begin
            m_held++;
         end else if (others != 8'h00) begin
            m_owner = scan(others, (m_owner + 1) % 8);
            m_held  = 1;
         end
      end else begin
         if (r != 8'h00) begin
            m_owner = scan(r, (m_owner + 1) % 8);
            m_held  = 1;
         end else begin
            m_owner = -1;
         end
      end
      if (m_owner >= 0) m_last = m_owner;
      e.v = (m_owner >= 0);
      e.g = e.v ? (8'h01 << m_owner) : 8'h00;
      e.i = e.v ? 3'(m_owner) : 3'd0;
      sb_q.push_back(e);
   endtask

   task automatic step(input logic [7:0] r);
      @(negedge clk);
      bus.req = r;
      model_step(r);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   // Async reset asserted between edges; outputs must clear before the next edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("rst_gnt", {24'h0, bus.gnt}, 32'h0);
      chk("rst_idx", {29'h0, bus.gnt_idx}, 32'h0);
      chk("rst_valid", {31'h0, bus.gnt_valid}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.req = 8'h00;
      rst_n   = 1'b1;
      m_owner = -1;
      m_held  = 0;
      m_last  = 7;
      model_step(8'h00);
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation after each edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_valid", {31'h0, bus.gnt_valid}, {31'h0, e.v});
            chk("sb_gnt", {24'h0, bus.gnt}, {24'h0, e.g});
            if (e.v) chk("sb_idx", {29'h0, bus.gnt_idx}, {29'h0, e.i});
         end
      end
   end

   initial begin : stim
      logic [7:0] cur;
      int         mode;
      bus.req = 8'h00;
      rst_n   = 1'b1;
      do_reset();
      repeat (3) step(8'h00);

      // Single request, one-cycle latency, then release to idle.
      step(8'h20);
      after_edge();
      chk("t1_gnt", {24'h0, bus.gnt}, 32'h20);
      chk("t1_idx", {29'h0, bus.gnt_idx}, 32'd5);
      chk("t1_valid", {31'h0, bus.gnt_valid}, 32'd1);
      step(8'h00);
      after_edge();
      chk("t1_rel_gnt", {24'h0, bus.gnt}, 32'h0);
      chk("t1_rel_valid", {31'h0, bus.gnt_valid}, 32'd0);

      // All requesting from reset: rotation with MAX_HOLD-cycle slots.
      do_reset();
      repeat (9 * MAX_HOLD + 2) step(8'hFF);
      step(8'h00);

      // Owner 2 drops as requester 4 (and 0) rise: switch with no idle cycle.
      repeat (2) step(8'h04);
      step(8'h11);
      after_edge();
      chk("t3_gnt", {24'h0, bus.gnt}, 32'h10);
      chk("t3_idx", {29'h0, bus.gnt_idx}, 32'd4);
      step(8'h00);

      // Lone requester saturates, then is preempted as soon as 6 appears.
      repeat (40) step(8'h08);
      step(8'h48);
      after_edge();
      chk("t4_gnt", {24'h0, bus.gnt}, 32'h40);

      // Wrap-around from ptr=7.
      do_reset();
      step(8'h81);
      after_edge();
      chk("t5_idx0", {29'h0, bus.gnt_idx}, 32'd0);
      step(8'h80);
      after_edge();
      chk("t5_idx7", {29'h0, bus.gnt_idx}, 32'd7);
      step(8'h01);
      after_edge();
      chk("t5_idx0b", {29'h0, bus.gnt_idx}, 32'd0);

      // Reset mid-grant, then the ptr=7 rule applies again.
      repeat (3) step(8'h90);
      do_reset();
      step(8'h90);
      after_edge();
      chk("t6_idx", {29'h0, bus.gnt_idx}, 32'd4);
      chk("t6_gnt", {24'h0, bus.gnt}, 32'h10);

      // Randomized traffic in phases of different density and stickiness.
      cur  = 8'h00;
      mode = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n % 64 == 0) mode = int'($urandom_range(0, 3));
         case (mode)
            0:       cur = 8'($urandom);
            1:       cur = 8'($urandom) & 8'($urandom) & 8'($urandom);
            2:       if ($urandom_range(0, 7) == 0) cur = 8'($urandom);
            default: cur = 8'($urandom) | 8'($urandom);
         endcase
         step(cur);
      end

      repeat (2) step(8'h00);
      @(posedge clk);
      #2;
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
